pll_reset_sequencer: RTL and testbench

Consumes the clock and lock indication produced by the on-chip PLL and turns them into a clean, clock-synchronous system reset for all logic running in the PLL output domain. It synchronizes the asynchronous lock input, requires lock to remain stable for a programmable settle period before releasing reset, and re-asserts reset immediately on lock loss. It sits directly after the PLL wrapper in the top level, ahead of the game logic, display and input blocks.

---
 rtl/pll_reset_sequencer_pkg.sv | 21 ++
 rtl/pll_reset_sequencer_if.sv | 21 ++
 rtl/pll_reset_sequencer_sync_ff.sv | 26 ++
 rtl/pll_reset_sequencer.sv | 116 +++++++++++
 tb/tb_pll_reset_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and helpers for the PLL reset sequencer: FSM state encoding,
// loss-counter width and the sizing function for the settle/hold counter.
package pll_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } pll_state_t;

  localparam int LOSS_CNT_W = 8;

  // One counter serves both the settle and hold phases, so size it for the larger.
  function automatic int cnt_width(input int settle_cycles, input int hold_cycles);
    int max_cycles;
    max_cycles = (settle_cycles > hold_cycles) ? settle_cycles : hold_cycles;
    return $clog2(max_cycles) + 1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Sequencer-facing signal bundle: PLL lock in, system reset and status out.
// loss_count exists only when LOCK_LOSS_COUNT_EN is defined.
interface pll_reset_sequencer_if;
  import pll_pkg::*;

  logic lock_in;
  logic rst_out;
  logic ready;
  logic lock_lost;
`ifdef LOCK_LOSS_COUNT_EN
  logic [LOSS_CNT_W-1:0] loss_count;

  modport master (input lock_in, output rst_out, output ready, output lock_lost,
                  output loss_count);
  modport slave  (output lock_in, input rst_out, input ready, input lock_lost,
                  input loss_count);
`else
  modport master (input lock_in, output rst_out, output ready, output lock_lost);
  modport slave  (output lock_in, input rst_out, input ready, input lock_lost);
`endif
endinterface

// File: rtl/pll_reset_sequencer_sync_ff.sv
// Parameterized N-stage synchronizer with asynchronous active-high reset;
// also used for the button inputs.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its predecessor's pre-edge value; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns the PLL lock indication into a clean synchronous system reset.
// Optional saturating lock-loss counter enabled by LOCK_LOSS_COUNT_EN.
module pll_reset_sequencer
  import pll_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pll_reset_sequencer_if.master bus
);

  localparam int              CNT_W       = cnt_width(SETTLE_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  pll_state_t       r_state;
  pll_state_t       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_lock_s;
  logic             w_loss_event;
  logic             r_rst_out;
  logic             r_ready;
  logic             r_lock_lost;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.lock_in),
    .o_q (w_lock_s)
  );

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    unique case (r_state)
      WAIT_LOCK: begin
        w_next_cnt = '0;
        if (w_lock_s) w_next_state = SETTLE;
      end
      SETTLE: begin
        if (!w_lock_s) begin
          w_next_state = WAIT_LOCK;
          w_next_cnt   = '0;
        end else if (r_cnt == SETTLE_LAST) begin
          w_next_state = RUN;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      RUN: begin
        w_next_cnt = '0;
        if (!w_lock_s) w_next_state = LOST;
      end
      LOST: begin
        // Hold time runs regardless of lock so a flapping PLL cannot shorten it.
        if (r_cnt == HOLD_LAST) begin
          w_next_state = WAIT_LOCK;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_next_state = WAIT_LOCK;
        w_next_cnt   = '0;
      end
    endcase
  end

  assign w_loss_event = (r_state == RUN) && !w_lock_s;

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself and never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= WAIT_LOCK;
      r_cnt       <= '0;
      r_rst_out   <= 1'b1;
      r_ready     <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_next_cnt;
      r_rst_out <= (w_next_state != RUN);
      r_ready   <= (w_next_state == RUN);
      if (w_loss_event) r_lock_lost <= 1'b1;
    end
  end

  assign bus.rst_out   = r_rst_out;
  assign bus.ready     = r_ready;
  assign bus.lock_lost = r_lock_lost;

`ifdef LOCK_LOSS_COUNT_EN
  logic [LOSS_CNT_W-1:0] r_loss_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_loss_count <= '0;
    end else if (w_loss_event && (r_loss_count != {LOSS_CNT_W{1'b1}})) begin
      r_loss_count <= r_loss_count + LOSS_CNT_W'(1);
    end
  end

  assign bus.loss_count = r_loss_count;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed scenarios plus random
// lock waveforms compared against a sliding-window model of the lock history.
module tb_pll_reset_sequencer;

  localparam int SYNC   = 2;
  localparam int SETTLE = 8;
  localparam int HOLD   = 4;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .SYNC_STAGES   (SYNC),
    .SETTLE_CYCLES (SETTLE),
    .HOLD_CYCLES   (HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: lock_s history as a list of per-edge samples; release is
  // granted when the last SETTLE+1 samples are all 1 and the hold time has elapsed.
  int t;
  bit hist_q[$];
  bit ls_q[$];
  bit m_run;
  int m_lost_edge;
  bit m_lost_flag;
  int m_loss_cnt;

  task automatic model_reset();
    t           = 0;
    hist_q      = {1'b0};
    ls_q        = {1'b0};
    m_run       = 1'b0;
    m_lost_edge = -HOLD;
    m_lost_flag = 1'b0;
    m_loss_cnt  = 0;
  endtask

  task automatic model_edge(input bit l);
    bit win_ok;
    t++;
    hist_q.push_back(l);
    ls_q.push_back((t - SYNC + 1 >= 1) ? hist_q[t-SYNC+1] : 1'b0);
    if (m_run) begin
      if (!ls_q[t-1]) begin
        m_run       = 1'b0;
        m_lost_edge = t;
        m_lost_flag = 1'b1;
        if (m_loss_cnt < 255) m_loss_cnt++;
      end
    end else if (t >= m_lost_edge + HOLD + SETTLE + 1) begin
      win_ok = 1'b1;
      for (int k = t - SETTLE - 1; k <= t - 1; k++) if (!ls_q[k]) win_ok = 1'b0;
      if (win_ok) m_run = 1'b1;
    end
  endtask

  // Drive lock_in at a falling edge, let one rising edge happen, return at the next falling edge.
  task automatic cycle(input bit l);
    bus.lock_in = l;
    @(posedge clk);
    model_edge(l);
    @(negedge clk);
  endtask

  task automatic do_reset(input bit l);
    rst         = 1'b1;
    bus.lock_in = l;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.lock_in = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.rst_out !== 1'b1) begin n_errors++; $display("FAIL reset rst_out got %b exp 1", bus.rst_out); end
    n_checks++;
    if (bus.ready !== 1'b0) begin n_errors++; $display("FAIL reset ready got %b exp 0", bus.ready); end
    n_checks++;
    if (bus.lock_lost !== 1'b0) begin n_errors++; $display("FAIL reset lock_lost got %b exp 0", bus.lock_lost); end
`ifdef LOCK_LOSS_COUNT_EN
    n_checks++;
    if (bus.loss_count !== 8'd0) begin n_errors++; $display("FAIL reset loss_count got %0d exp 0", bus.loss_count); end
`endif
  endtask

  task automatic test_powerup();
    do_reset(1'b1);
    for (int k = 1; k <= 13; k++) begin
      cycle(1'b1);
      n_checks++;
      if (bus.rst_out !== (k < 11)) begin
        n_errors++; $display("FAIL powerup rst_out edge=%0d got %b exp %b", k, bus.rst_out, (k < 11));
      end
      n_checks++;
      if (bus.ready !== (k >= 11)) begin
        n_errors++; $display("FAIL powerup ready edge=%0d got %b exp %b", k, bus.ready, (k >= 11));
      end
    end
  endtask

  task automatic test_settle_abort();
    do_reset(1'b0);
    repeat (3) cycle(1'b0);
    for (int k = 1; k <= 7; k++) begin
      cycle(k <= 5);
      n_checks++;
      if (bus.rst_out !== 1'b1) begin n_errors++; $display("FAIL abort early rst_out edge=%0d got %b exp 1", k, bus.rst_out); end
    end
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b1);
      n_checks++;
      if (bus.rst_out !== (k < 11)) begin
        n_errors++; $display("FAIL abort rst_out edge=%0d got %b exp %b", k, bus.rst_out, (k < 11));
      end
      n_checks++;
      if (bus.lock_lost !== 1'b0) begin n_errors++; $display("FAIL abort lock_lost edge=%0d got %b exp 0", k, bus.lock_lost); end
    end
  endtask

  task automatic test_lock_loss();
    bit exp_rst;
    do_reset(1'b1);
    repeat (13) cycle(1'b1);
    n_checks++;
    if (bus.ready !== 1'b1) begin n_errors++; $display("FAIL loss pre ready got %b exp 1", bus.ready); end
    for (int k = 1; k <= 18; k++) begin
      cycle(k != 1);
      exp_rst = (k >= 3) && (k < 16);
      n_checks++;
      if (bus.rst_out !== exp_rst) begin n_errors++; $display("FAIL loss rst_out edge=%0d got %b exp %b", k, bus.rst_out, exp_rst); end
      n_checks++;
      if (bus.ready !== !exp_rst) begin n_errors++; $display("FAIL loss ready edge=%0d got %b exp %b", k, bus.ready, !exp_rst); end
      n_checks++;
      if (bus.lock_lost !== (k >= 3)) begin n_errors++; $display("FAIL loss lock_lost edge=%0d got %b exp %b", k, bus.lock_lost, (k >= 3)); end
`ifdef LOCK_LOSS_COUNT_EN
      n_checks++;
      if (bus.loss_count !== ((k >= 3) ? 8'd1 : 8'd0)) begin
        n_errors++; $display("FAIL loss loss_count edge=%0d got %0d exp %0d", k, bus.loss_count, (k >= 3) ? 1 : 0);
      end
`endif
    end
  endtask

`ifdef LOCK_LOSS_COUNT_EN
  task automatic test_saturation();
    do_reset(1'b1);
    repeat (11) cycle(1'b1);
    for (int ev = 1; ev <= 260; ev++) begin
      cycle(1'b0);
      repeat (15) cycle(1'b1);
      n_checks++;
      if (bus.loss_count !== 8'((ev < 255) ? ev : 255)) begin
        n_errors++; $display("FAIL sat loss_count event=%0d got %0d exp %0d", ev, bus.loss_count, (ev < 255) ? ev : 255);
      end
    end
    n_checks++;
    if (bus.ready !== 1'b1) begin n_errors++; $display("FAIL sat ready got %b exp 1", bus.ready); end
  endtask
`endif

  task automatic test_async_reset();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset(1'b1);
      repeat (11) cycle(1'b1);
      cycle(1'b0);
      if (pass == 0) repeat (15) cycle(1'b1);
      else repeat (4) cycle(1'b1);
      n_checks++;
      if (bus.rst_out !== (pass == 1)) begin n_errors++; $display("FAIL async pre%0d rst_out got %b exp %b", pass, bus.rst_out, (pass == 1)); end
      n_checks++;
      if (bus.lock_lost !== 1'b1) begin n_errors++; $display("FAIL async pre%0d lock_lost got %b exp 1", pass, bus.lock_lost); end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (bus.rst_out !== 1'b1) begin n_errors++; $display("FAIL async%0d rst_out got %b exp 1", pass, bus.rst_out); end
      n_checks++;
      if (bus.ready !== 1'b0) begin n_errors++; $display("FAIL async%0d ready got %b exp 0", pass, bus.ready); end
      n_checks++;
      if (bus.lock_lost !== 1'b0) begin n_errors++; $display("FAIL async%0d lock_lost got %b exp 0", pass, bus.lock_lost); end
`ifdef LOCK_LOSS_COUNT_EN
      n_checks++;
      if (bus.loss_count !== 8'd0) begin n_errors++; $display("FAIL async%0d loss_count got %0d exp 0", pass, bus.loss_count); end
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int n_cyc;
    int seg_len;
    bit lvl;
    do_reset(1'b0);
    n_cyc = 0;
    lvl   = 1'b1;
    while (n_cyc < 3000) begin
      seg_len = lvl ? int'($urandom_range(1, 25)) : int'($urandom_range(1, 5));
      for (int i = 0; i < seg_len; i++) begin
        cycle(lvl);
        n_cyc++;
        n_checks++;
        if (bus.rst_out !== !m_run) begin n_errors++; $display("FAIL rand rst_out cyc=%0d got %b exp %b", n_cyc, bus.rst_out, !m_run); end
        n_checks++;
        if (bus.ready !== m_run) begin n_errors++; $display("FAIL rand ready cyc=%0d got %b exp %b", n_cyc, bus.ready, m_run); end
        n_checks++;
        if (bus.lock_lost !== m_lost_flag) begin n_errors++; $display("FAIL rand lock_lost cyc=%0d got %b exp %b", n_cyc, bus.lock_lost, m_lost_flag); end
`ifdef LOCK_LOSS_COUNT_EN
        n_checks++;
        if (bus.loss_count !== 8'(m_loss_cnt)) begin n_errors++; $display("FAIL rand loss_count cyc=%0d got %0d exp %0d", n_cyc, bus.loss_count, m_loss_cnt); end
`endif
      end
      lvl = !lvl;
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.lock_in = 1'b0;
    test_reset();
    test_powerup();
    test_settle_abort();
    test_lock_loss();
`ifdef LOCK_LOSS_COUNT_EN
    test_saturation();
`endif
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
